pipeline_stage_skid_reg: RTL and testbench

//  Generic inter-stage pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) with valid/ready flow control,

---
 rtl/pipeline_stage_skid_reg.sv | 195 +++++++++++++++++++
 tb/tb_pipeline_stage_skid_reg.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_stage_skid_reg.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_stage_skid_reg
//  Description : Inter-stage pipeline register with valid/ready handshaking,
//                synchronous flush and an optional 2-entry skid buffer.
//
//                With the skid buffer enabled, in_ready is decoded from the
//                state register. A downstream stall therefore never forms a
//                combinational ready path back through the pipeline.
//
//                The control bundle reads as all-zero whenever no valid op
//                is held, so a bubble is harmless downstream. The data
//                bundle is simply held.
//
//  Ports       : clk        - clock, all state updates on posedge
//                rstN       - asynchronous active-low reset
//                flush      - synchronous kill of all held entries
//                in_valid   - upstream offers an op
//                in_ready   - stage can accept an op this cycle
//                in_ctrl    - upstream control bundle  [CTRL_W]
//                in_data    - upstream data bundle     [DATA_W]
//                out_valid  - main entry holds a valid op
//                out_ready  - downstream accepts the main entry
//                out_ctrl   - main entry control (zero when !out_valid)
//                out_data   - main entry data
//                occupancy  - entries held: 0, 1 or 2
//
//  Revision    : 1.0 - initial release
// ============================================================================
module pipeline_stage_skid_reg #(
    parameter int CTRL_W  = 4,
    parameter int DATA_W  = 72,
    parameter int SKID_EN = 1
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    // The state encoding equals the number of held entries, so the
    // occupancy output is the state register itself.
    localparam logic [1:0] c_st_empty = 2'd0;
    localparam logic [1:0] c_st_busy  = 2'd1;
    localparam logic [1:0] c_st_full  = 2'd2;

    logic [1:0]        state_q,     state_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;

    logic              in_fire;
    logic              out_fire;

    assign in_fire  = in_valid  & in_ready;
    assign out_fire = out_valid & out_ready;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= c_st_empty;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic (flush overrides every transition)
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_st_empty: begin
                if (in_fire) begin
                    state_d = c_st_busy;
                end
            end
            c_st_busy: begin
                // Without the skid buffer, in_ready is low whenever the
                // main entry stalls, so the FULL branch is unreachable.
                if (in_fire && !out_fire && (SKID_EN != 0)) begin
                    state_d = c_st_full;
                end else if (!in_fire && out_fire) begin
                    state_d = c_st_empty;
                end
            end
            c_st_full: begin
                if (out_fire) begin
                    state_d = c_st_busy;
                end
            end
            default: begin
                state_d = c_st_empty;
            end
        endcase
        if (flush) begin
            state_d = c_st_empty;
        end
    end

    // ------------------------------------------------------------------
    // Entry registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            main_ctrl_q <= '0;
            main_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
        end else begin
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
        end
    end

    always_comb begin
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;
        if (flush) begin
            // Any op accepted in the flush cycle is dropped. The data
            // registers keep their contents, because only ctrl must read
            // as a bubble.
            main_ctrl_d = '0;
            skid_ctrl_d = '0;
        end else begin
            case (state_q)
                c_st_empty: begin
                    if (in_fire) begin
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                    end
                end
                c_st_busy: begin
                    if (in_fire && out_fire) begin
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                    end else if (in_fire) begin
                        skid_ctrl_d = in_ctrl;
                        skid_data_d = in_data;
                    end else if (out_fire) begin
                        main_ctrl_d = '0;
                    end
                end
                c_st_full: begin
                    // The skid entry is younger, so it only moves into
                    // main once the older main entry has left.
                    if (out_fire) begin
                        main_ctrl_d = skid_ctrl_q;
                        main_data_d = skid_data_q;
                        skid_ctrl_d = '0;
                    end
                end
                default: begin
                    main_ctrl_d = '0;
                    skid_ctrl_d = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    always_comb begin
        out_valid = (state_q != c_st_empty);
        out_ctrl  = main_ctrl_q;
        out_data  = main_data_q;
        occupancy = state_q;
    end

    generate
        if (SKID_EN != 0) begin : g_skid
            assign in_ready = (state_q != c_st_full);
        end else begin : g_no_skid
            assign in_ready = out_ready | (state_q == c_st_empty);
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pipeline_stage_skid_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipeline_stage_skid_reg
//  Description : Directed, table-driven bench for pipeline_stage_skid_reg.
//                One instance uses the skid buffer and one does not.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_stage_skid_reg;

    localparam int CTRL_W = 4;
    localparam int DATA_W = 72;

    logic              clk;
    logic              rstN;

    // Instance with skid buffer
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        occupancy;

    // Instance without skid buffer
    logic              n_flush;
    logic              n_in_valid;
    logic              n_in_ready;
    logic [CTRL_W-1:0] n_in_ctrl;
    logic [DATA_W-1:0] n_in_data;
    logic              n_out_valid;
    logic              n_out_ready;
    logic [CTRL_W-1:0] n_out_ctrl;
    logic [DATA_W-1:0] n_out_data;
    logic [1:0]        n_occupancy;

    int n_vec;
    int n_fail;

    pipeline_stage_skid_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .SKID_EN(1)) dut (
        .clk       (clk),
        .rstN      (rstN),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    pipeline_stage_skid_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .SKID_EN(0)) dut_ns (
        .clk       (clk),
        .rstN      (rstN),
        .flush     (n_flush),
        .in_valid  (n_in_valid),
        .in_ready  (n_in_ready),
        .in_ctrl   (n_in_ctrl),
        .in_data   (n_in_data),
        .out_valid (n_out_valid),
        .out_ready (n_out_ready),
        .out_ctrl  (n_out_ctrl),
        .out_data  (n_out_data),
        .occupancy (n_occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       iv;
        logic       ordy;
        logic       fl;
        logic [3:0] ctrl;
        logic [7:0] d;
        logic       ov;
        logic [3:0] oc;
        logic [7:0] od;
        logic [1:0] occ;
        logic       ir;
    } vec_t;

    localparam int NVEC = 22;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic iv, input logic ordy, input logic fl,
                                input logic [3:0] ctrl, input logic [7:0] d,
                                input logic ov, input logic [3:0] oc, input logic [7:0] od,
                                input logic [1:0] occ, input logic ir);
        vec_t v;
        v.iv = iv; v.ordy = ordy; v.fl = fl; v.ctrl = ctrl; v.d = d;
        v.ov = ov; v.oc = oc; v.od = od; v.occ = occ; v.ir = ir;
        return v;
    endfunction

    function automatic logic [DATA_W-1:0] dx(input logic [7:0] d);
        return {64'hCAFE_F00D_0000_0000, d};
    endfunction

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Samples the skid instance's registered outputs against one expectation.
    task automatic chk_all(input string tag, input logic ov, input logic [3:0] oc,
                           input logic [DATA_W-1:0] od, input logic [1:0] occ, input logic ir);
        chk({tag, ".out_valid"}, DATA_W'(out_valid), DATA_W'(ov));
        chk({tag, ".out_ctrl"},  DATA_W'(out_ctrl),  DATA_W'(oc));
        chk({tag, ".out_data"},  out_data,           od);
        chk({tag, ".occupancy"}, DATA_W'(occupancy), DATA_W'(occ));
        chk({tag, ".in_ready"},  DATA_W'(in_ready),  DATA_W'(ir));
    endtask

    initial begin
        n_vec  = 0;
        n_fail = 0;

        //            iv    ordy  fl    ctrl  d       ov    oc    od      occ   ir
        // streaming: one op per cycle, no bubble
        vecs[0]  = mk(1'b1, 1'b1, 1'b0, 4'h1, 8'h11,  1'b1, 4'h1, 8'h11,  2'd1, 1'b1);
        vecs[1]  = mk(1'b1, 1'b1, 1'b0, 4'h2, 8'h22,  1'b1, 4'h2, 8'h22,  2'd1, 1'b1);
        vecs[2]  = mk(1'b1, 1'b1, 1'b0, 4'h3, 8'h33,  1'b1, 4'h3, 8'h33,  2'd1, 1'b1);
        vecs[3]  = mk(1'b1, 1'b1, 1'b0, 4'h4, 8'h44,  1'b1, 4'h4, 8'h44,  2'd1, 1'b1);
        vecs[4]  = mk(1'b0, 1'b1, 1'b0, 4'h0, 8'h00,  1'b0, 4'h0, 8'h44,  2'd0, 1'b1);
        // single op then bubble: ctrl drops to 0, data held
        vecs[5]  = mk(1'b1, 1'b1, 1'b0, 4'hA, 8'hAA,  1'b1, 4'hA, 8'hAA,  2'd1, 1'b1);
        vecs[6]  = mk(1'b0, 1'b1, 1'b0, 4'h0, 8'h00,  1'b0, 4'h0, 8'hAA,  2'd0, 1'b1);
        vecs[7]  = mk(1'b0, 1'b1, 1'b0, 4'h0, 8'h00,  1'b0, 4'h0, 8'hAA,  2'd0, 1'b1);
        // stall: A=7, B=8, C=9; C parks in skid, then B and C drain in order
        vecs[8]  = mk(1'b1, 1'b1, 1'b0, 4'h7, 8'h77,  1'b1, 4'h7, 8'h77,  2'd1, 1'b1);
        vecs[9]  = mk(1'b1, 1'b1, 1'b0, 4'h8, 8'h88,  1'b1, 4'h8, 8'h88,  2'd1, 1'b1);
        vecs[10] = mk(1'b1, 1'b0, 1'b0, 4'h9, 8'h99,  1'b1, 4'h8, 8'h88,  2'd2, 1'b0);
        vecs[11] = mk(1'b1, 1'b0, 1'b0, 4'h6, 8'h66,  1'b1, 4'h8, 8'h88,  2'd2, 1'b0);
        vecs[12] = mk(1'b1, 1'b1, 1'b0, 4'h6, 8'h66,  1'b1, 4'h9, 8'h99,  2'd1, 1'b1);
        vecs[13] = mk(1'b0, 1'b1, 1'b0, 4'h0, 8'h00,  1'b0, 4'h0, 8'h99,  2'd0, 1'b1);
        // flush while FULL with in_valid (ctrl 5 must never surface)
        vecs[14] = mk(1'b1, 1'b0, 1'b0, 4'h1, 8'h01,  1'b1, 4'h1, 8'h01,  2'd1, 1'b1);
        vecs[15] = mk(1'b1, 1'b0, 1'b0, 4'h2, 8'h02,  1'b1, 4'h1, 8'h01,  2'd2, 1'b0);
        vecs[16] = mk(1'b1, 1'b0, 1'b1, 4'h5, 8'h55,  1'b0, 4'h0, 8'h01,  2'd0, 1'b1);
        vecs[17] = mk(1'b0, 1'b1, 1'b0, 4'h0, 8'h00,  1'b0, 4'h0, 8'h01,  2'd0, 1'b1);
        // flush while BUSY with an accepted op, and flush while EMPTY
        vecs[18] = mk(1'b1, 1'b1, 1'b0, 4'h3, 8'h03,  1'b1, 4'h3, 8'h03,  2'd1, 1'b1);
        vecs[19] = mk(1'b1, 1'b1, 1'b1, 4'h5, 8'h55,  1'b0, 4'h0, 8'h03,  2'd0, 1'b1);
        vecs[20] = mk(1'b0, 1'b1, 1'b0, 4'h0, 8'h00,  1'b0, 4'h0, 8'h03,  2'd0, 1'b1);
        vecs[21] = mk(1'b1, 1'b1, 1'b1, 4'h5, 8'h55,  1'b0, 4'h0, 8'h03,  2'd0, 1'b1);

        // Reset held with a valid op on the input
        rstN        = 1'b0;
        flush       = 1'b0;
        in_valid    = 1'b1;
        in_ctrl     = 4'hF;
        in_data     = dx(8'hFF);
        out_ready   = 1'b1;
        n_flush     = 1'b0;
        n_in_valid  = 1'b0;
        n_in_ctrl   = 4'h0;
        n_in_data   = '0;
        n_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_all("reset", 1'b0, 4'h0, '0, 2'd0, 1'b1);
        chk("reset.ns_in_ready", DATA_W'(n_in_ready), DATA_W'(1'b1));
        @(negedge clk);
        rstN = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            in_valid  = vecs[i].iv;
            out_ready = vecs[i].ordy;
            flush     = vecs[i].fl;
            in_ctrl   = vecs[i].ctrl;
            in_data   = dx(vecs[i].d);
            @(posedge clk);
            #1;
            chk_all($sformatf("vec%0d", i), vecs[i].ov, vecs[i].oc,
                    dx(vecs[i].od), vecs[i].occ, vecs[i].ir);
        end

        // Asynchronous reset while FULL drops both entries immediately
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0; in_ctrl = 4'hC; in_data = dx(8'hC1);
        @(posedge clk);
        @(negedge clk);
        in_ctrl = 4'hD; in_data = dx(8'hD2);
        @(posedge clk);
        #1;
        chk("pre_areset.occupancy", DATA_W'(occupancy), DATA_W'(2'd2));
        #2;
        rstN = 1'b0;
        #1;
        chk_all("areset", 1'b0, 4'h0, '0, 2'd0, 1'b1);
        @(negedge clk);
        rstN = 1'b1; in_valid = 1'b0; out_ready = 1'b1;

        // Instance without skid buffer: combinational in_ready, occupancy <= 1
        @(negedge clk);
        n_in_valid = 1'b1; n_out_ready = 1'b0; n_in_ctrl = 4'h1; n_in_data = dx(8'h01);
        @(posedge clk);
        #1;
        chk("ns1.out_ctrl",  DATA_W'(n_out_ctrl),  DATA_W'(4'h1));
        chk("ns1.occupancy", DATA_W'(n_occupancy), DATA_W'(2'd1));
        chk("ns1.in_ready",  DATA_W'(n_in_ready),  DATA_W'(1'b0));
        @(negedge clk);
        n_in_ctrl = 4'h2; n_in_data = dx(8'h02);
        @(posedge clk);
        #1;
        chk("ns2.out_ctrl",  DATA_W'(n_out_ctrl),  DATA_W'(4'h1));
        chk("ns2.out_data",  n_out_data,           dx(8'h01));
        chk("ns2.occupancy", DATA_W'(n_occupancy), DATA_W'(2'd1));
        @(negedge clk);
        n_out_ready = 1'b1;
        #1;
        chk("ns3.in_ready_comb", DATA_W'(n_in_ready), DATA_W'(1'b1));
        @(posedge clk);
        #1;
        chk("ns3.out_valid", DATA_W'(n_out_valid), DATA_W'(1'b1));
        chk("ns3.out_ctrl",  DATA_W'(n_out_ctrl),  DATA_W'(4'h2));
        chk("ns3.out_data",  n_out_data,           dx(8'h02));
        chk("ns3.occupancy", DATA_W'(n_occupancy), DATA_W'(2'd1));
        @(negedge clk);
        n_in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("ns4.out_valid", DATA_W'(n_out_valid), DATA_W'(1'b0));
        chk("ns4.out_ctrl",  DATA_W'(n_out_ctrl),  DATA_W'(4'h0));
        chk("ns4.occupancy", DATA_W'(n_occupancy), DATA_W'(2'd0));
        chk("ns4.in_ready",  DATA_W'(n_in_ready),  DATA_W'(1'b1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
